// File: rtl/spi_cfg_pkg.sv
// -----------------------------------------------------------------------------
// spi_cfg_pkg
// Shared definitions for the SPI register-table sequencer:
//   - table entry layout (op[22:21], addr[20:8], data[7:0]);
//   - op-code constants (END / WR / WRV / WAIT);
//   - sequencer state encoding;
//   - where the GAP state hands control next;
//   - make_entry(): builds a table entry from its fields.
// -----------------------------------------------------------------------------
package spi_cfg_pkg;

  localparam int ENTRY_W  = 23;
  localparam int OP_MSB   = 22;
  localparam int OP_LSB   = 21;
  localparam int ADDR_MSB = 20;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
  localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

  typedef enum logic [1:0] {
    OP_END  = 2'b00,
    OP_WR   = 2'b01,
    OP_WRV  = 2'b10,
    OP_WAIT = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LOAD     = 4'd2,
    ST_ISSUE_WR = 4'd3,
    ST_WAIT_WR  = 4'd4,
    ST_GAP      = 4'd5,
    ST_ISSUE_RD = 4'd6,
    ST_WAIT_RD  = 4'd7,
    ST_CHECK    = 4'd8,
    ST_DELAY    = 4'd9,
    ST_NEXT     = 4'd10,
    ST_DONE     = 4'd11,
    ST_ERROR    = 4'd12
  } state_e;

  // Destination once the CSB-idle gap has elapsed.
  typedef enum logic [1:0] {
    GAP_TO_RD   = 2'd0,
    GAP_TO_NEXT = 2'd1,
    GAP_TO_WR   = 2'd2
  } gap_dst_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input op_e op,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {op, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_rom.sv
// -----------------------------------------------------------------------------
// spi_cfg_rom
// Synchronous configuration table, one cycle of read latency, 2**IDX_W entries
// of 23 bits. Unlisted indices read as END.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (clears the output register)
//   addr   in   table index
//   entry  out  registered table entry for the index presented last cycle
// -----------------------------------------------------------------------------
module spi_cfg_rom
  import spi_cfg_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   addr,
  output logic [ENTRY_W-1:0] entry
);

  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] entry_q;

  always_comb begin
    entry_d = make_entry(OP_END, 13'h0000, 8'h00);
    case (int'(addr))
      0:       entry_d = make_entry(OP_WR,   13'h0000, 8'h3C);
      1:       entry_d = make_entry(OP_WRV,  13'h0014, 8'hA5);
      2:       entry_d = make_entry(OP_WAIT, 13'h0000, 8'h02);
      3:       entry_d = make_entry(OP_WR,   13'h0123, 8'h5A);
      4:       entry_d = make_entry(OP_WAIT, 13'h0000, 8'h00);
      5:       entry_d = make_entry(OP_WRV,  13'h1FFF, 8'h0F);
      6:       entry_d = make_entry(OP_END,  13'h0000, 8'h00);
      default: entry_d = make_entry(OP_END,  13'h0000, 8'h00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// spi_reg_sequencer
// Walks the configuration table and drives the user port of the 3-wire SPI
// master: single-byte writes, optional read-back verify with retries, WAIT
// delays, and a CSB-idle gap after every SPI transaction. Reports completion
// or the first failing entry.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (shared with master)
//   cfg_start           one-cycle pulse, (re)runs the table when idle
//   spi_write_en/read_en one-cycle requests to the master
//   spi_data_addr/write register address and write byte (held through a transfer)
//   spi_write_end/read_end one-cycle completion pulses from the master
//   spi_data_read       read byte, valid from the cycle after spi_read_end
//   cfg_busy            sequence in progress
//   cfg_done/cfg_error  sticky completion / failure flags
//   err_index/err_data  failing entry index and last byte read there
// Handshake: an enable is a single-cycle request; the master answers with one
// single-cycle end pulse of the matching kind. The sequencer holds address and
// data from LOAD until that end pulse and never raises both enables together.
// -----------------------------------------------------------------------------
module spi_reg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 4095,
  parameter int WAIT_UNIT  = 1024,
  parameter int AUTO_START = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic              spi_write_en,
  output logic              spi_read_en,
  output logic [12:0]       spi_data_addr,
  output logic [7:0]        spi_data_write,
  input  logic              spi_write_end,
  input  logic              spi_read_end,
  input  logic [7:0]        spi_data_read,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [IDX_W-1:0]  err_index,
  output logic [7:0]        err_data
);

  // One down-counter serves gap, delay and watchdog; size it for the longest.
  localparam int WAIT_MAX = 255 * WAIT_UNIT;
  localparam int CNT_A    = (WAIT_MAX > TIMEOUT) ? WAIT_MAX : TIMEOUT;
  localparam int CNT_MAX  = (CNT_A > GAP_CYCLES) ? CNT_A : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDG_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UNIT_C   = CNT_W'(WAIT_UNIT);
  localparam logic [2:0]       RETRY_MX = 3'(MAX_RETRY);

  state_e             state_q, state_d;
  gap_dst_e           gap_dst_q, gap_dst_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_wrv_q, is_wrv_d;
  logic [12:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   err_index_q, err_index_d;
  logic [7:0]         err_data_q, err_data_d;
  logic               start_pend_q, start_pend_d;

  logic [ENTRY_W-1:0] rom_entry;
  op_e                rom_op;
  logic [12:0]        rom_addr;
  logic [7:0]         rom_data;

  spi_cfg_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (idx_q),
    .entry (rom_entry)
  );

  assign rom_op   = op_e'(rom_entry[OP_MSB:OP_LSB]);
  assign rom_addr = rom_entry[ADDR_MSB:ADDR_LSB];
  assign rom_data = rom_entry[DATA_MSB:DATA_LSB];

  always_comb begin
    state_d      = state_q;
    gap_dst_d    = gap_dst_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    is_wrv_d     = is_wrv_q;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    err_index_d  = err_index_q;
    err_data_d   = err_data_q;
    // Auto-start request lives only for the first cycle after reset release.
    start_pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start || start_pend_q) begin
          state_d     = ST_FETCH;
          idx_d       = '0;
          retry_d     = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          err_data_d  = '0;
        end
      end

      ST_FETCH: state_d = ST_LOAD;

      ST_LOAD: begin
        case (rom_op)
          OP_END: begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          OP_WAIT: begin
            // data=0 passes through DELAY for a single cycle.
            cnt_d   = CNT_W'(rom_data) * UNIT_C;
            state_d = ST_DELAY;
          end
          default: begin
            addr_d   = rom_addr;
            data_d   = rom_data;
            is_wrv_d = (rom_op == OP_WRV);
            state_d  = ST_ISSUE_WR;
          end
        endcase
      end

      ST_ISSUE_WR: begin
        cnt_d   = WDG_LOAD;
        state_d = ST_WAIT_WR;
      end

      ST_WAIT_WR: begin
        // End pulse is checked first so it wins over a same-cycle expiry.
        if (spi_write_end) begin
          cnt_d     = GAP_LOAD;
          gap_dst_d = is_wrv_q ? GAP_TO_RD : GAP_TO_NEXT;
          state_d   = ST_GAP;
        end else if (cnt_q == '0) begin
          state_d     = ST_ERROR;
          busy_d      = 1'b0;
          error_d     = 1'b1;
          err_index_d = idx_q;
          err_data_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) begin
          case (gap_dst_q)
            GAP_TO_RD: state_d = ST_ISSUE_RD;
            GAP_TO_WR: state_d = ST_ISSUE_WR;
            default:   state_d = ST_NEXT;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ISSUE_RD: begin
        cnt_d   = WDG_LOAD;
        state_d = ST_WAIT_RD;
      end

      ST_WAIT_RD: begin
        if (spi_read_end) begin
          state_d = ST_CHECK;
        end else if (cnt_q == '0) begin
          state_d     = ST_ERROR;
          busy_d      = 1'b0;
          error_d     = 1'b1;
          err_index_d = idx_q;
          err_data_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (spi_data_read == data_q) begin
          cnt_d     = GAP_LOAD;
          gap_dst_d = GAP_TO_NEXT;
          state_d   = ST_GAP;
        end else if (retry_q < RETRY_MX) begin
          // The retry write also waits out the gap so CSB-high time is kept.
          retry_d   = retry_q + 3'd1;
          cnt_d     = GAP_LOAD;
          gap_dst_d = GAP_TO_WR;
          state_d   = ST_GAP;
        end else begin
          state_d     = ST_ERROR;
          busy_d      = 1'b0;
          error_d     = 1'b1;
          err_index_d = idx_q;
          err_data_d  = spi_data_read;
        end
      end

      ST_DELAY: begin
        if (cnt_q == '0) state_d = ST_NEXT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      ST_NEXT: begin
        // Last index ends the table rather than wrapping to 0.
        if (idx_q == {IDX_W{1'b1}}) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          retry_d = '0;
          state_d = ST_FETCH;
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gap_dst_q    <= GAP_TO_NEXT;
      idx_q        <= '0;
      retry_q      <= '0;
      cnt_q        <= '0;
      is_wrv_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_index_q  <= '0;
      err_data_q   <= '0;
      start_pend_q <= (AUTO_START != 0);
    end else begin
      state_q      <= state_d;
      gap_dst_q    <= gap_dst_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      is_wrv_q     <= is_wrv_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_index_q  <= err_index_d;
      err_data_q   <= err_data_d;
      start_pend_q <= start_pend_d;
    end
  end

  // Enables decode single-cycle states, so they are one cycle wide and exclusive.
  assign spi_write_en   = (state_q == ST_ISSUE_WR);
  assign spi_read_en    = (state_q == ST_ISSUE_RD);
  assign spi_data_addr  = addr_q;
  assign spi_data_write = data_q;
  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;
  assign cfg_error      = error_q;
  assign err_index      = err_index_q;
  assign err_data       = err_data_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_sequencer
// Bench for spi_reg_sequencer with a behavioural SPI master. A table-walk model
// turns the expected register table plus the per-run master behaviour
// (mismatch counts, stall point) into the expected transaction list and the
// expected final status.
// -----------------------------------------------------------------------------
module tb_spi_reg_sequencer;

  localparam int IDX_W = 6;
  localparam int DEPTH = 64;
  localparam int GAP   = 16;
  localparam int MAXR  = 3;
  localparam int TMO   = 4095;
  localparam int WUNIT = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_start = 1'b0;
  logic             spi_write_end = 1'b0;
  logic             spi_read_end = 1'b0;
  logic [7:0]       spi_data_read = 8'h00;
  logic             spi_write_en, spi_read_en;
  logic [12:0]      spi_data_addr;
  logic [7:0]       spi_data_write;
  logic             cfg_busy, cfg_done, cfg_error;
  logic [IDX_W-1:0] err_index;
  logic [7:0]       err_data;

  spi_reg_sequencer #(
    .IDX_W      (IDX_W),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR),
    .TIMEOUT    (TMO),
    .WAIT_UNIT  (WUNIT),
    .AUTO_START (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .spi_write_en   (spi_write_en),
    .spi_read_en    (spi_read_en),
    .spi_data_addr  (spi_data_addr),
    .spi_data_write (spi_data_write),
    .spi_write_end  (spi_write_end),
    .spi_read_end   (spi_read_end),
    .spi_data_read  (spi_data_read),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error),
    .err_index      (err_index),
    .err_data       (err_data)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [22:0] tbl [DEPTH];
  int          mm  [DEPTH];            // mismatching reads before a good one
  logic [7:0]  bad [DEPTH][MAXR+1];    // wrong bytes returned per attempt

  logic [21:0] exp_q[$];               // {is_read, addr, data}
  int          gap_q[$];               // minimum cycles since previous end pulse
  logic [7:0]  rd_q[$];                // bytes the master returns, in order

  int          stall_at = -1;
  bit          exp_done, exp_err;
  int          exp_eidx;
  logic [7:0]  exp_edata;

  int          ncyc = 0;
  int          last_end = -100000;
  int          last_en = 0;
  int          err_cyc = 0;
  int          start_cyc = 0;
  int          txn_n = 0;
  int          pend = 0;
  bit          pend_rd = 1'b0;
  bit          chk_lat = 1'b0;
  bit          prev_fin = 1'b0;
  logic [12:0] cap_addr;
  logic [7:0]  cap_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_ge(input string tag, input int obs, input int minv);
    checks++;
    assert (obs >= minv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, minv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_model();
    int n, pg, op;
    logic [12:0] ad;
    logic [7:0]  dt;
    exp_q.delete(); gap_q.delete(); rd_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 0; exp_edata = 8'h00;
    txn_n = 0;
    n = 0;
    pg = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op = int'(tbl[i][22:21]);
      ad = tbl[i][20:8];
      dt = tbl[i][7:0];
      if (op == 0) begin exp_done = 1'b1; return; end
      if (op == 3) begin
        if (int'(dt) * WUNIT > pg) pg = int'(dt) * WUNIT;
        continue;
      end
      for (int a = 0; a <= MAXR; a++) begin
        exp_q.push_back({1'b0, ad, dt}); gap_q.push_back(pg);
        pg = GAP + 1;
        if (n == stall_at) begin exp_err = 1'b1; exp_eidx = i; return; end
        n++;
        if (op == 1) break;
        exp_q.push_back({1'b1, ad, dt}); gap_q.push_back(GAP + 1);
        if (n == stall_at) begin exp_err = 1'b1; exp_eidx = i; return; end
        n++;
        if (a >= mm[i]) begin rd_q.push_back(dt); break; end
        rd_q.push_back(bad[i][a]);
        if (a == MAXR) begin
          exp_err = 1'b1; exp_eidx = i; exp_edata = bad[i][a];
          return;
        end
      end
    end
    exp_done = 1'b1;
  endtask

  // ---------------- master model + transaction monitor ----------------
  always @(negedge clk) begin
    logic [21:0] e;
    int g;
    ncyc++;
    spi_write_end = 1'b0;
    spi_read_end  = 1'b0;
    if (!rst_n) begin
      pend = 0;
      prev_fin = 1'b0;
    end else begin
      if (cfg_start) start_cyc = ncyc;
      if (spi_write_en || spi_read_en) begin
        chk("en_exclusive", {31'b0, spi_write_en & spi_read_en}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_enable", {spi_read_en, spi_data_addr, spi_data_write}, 32'h3FFFFF);
        end else begin
          e = exp_q.pop_front();
          g = gap_q.pop_front();
          chk("txn", {10'b0, spi_read_en, spi_data_addr, spi_data_write}, {10'b0, e});
          chk_ge("gap_since_end", ncyc - last_end, g);
        end
        if (chk_lat) begin
          chk("start_latency", ncyc - start_cyc, 32'd3);
          chk_lat = 1'b0;
        end
        last_en  = ncyc;
        cap_addr = spi_data_addr;
        cap_data = spi_data_write;
        pend_rd  = spi_read_en;
        if (txn_n == stall_at) pend = 0;
        else pend = $urandom_range(10, 60);
        txn_n++;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          chk("held_addr_data", {11'b0, spi_data_addr, spi_data_write}, {11'b0, cap_addr, cap_data});
          last_end = ncyc;
          if (pend_rd) begin
            spi_read_end  = 1'b1;
            spi_data_read = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          end else begin
            spi_write_end = 1'b1;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          // Wrong-kind end pulse, which the sequencer must ignore.
          if (pend_rd) spi_write_end = 1'b1;
          else         spi_read_end  = 1'b1;
        end
      end
      if ((cfg_done || cfg_error) && !prev_fin) begin
        err_cyc = ncyc;
        chk("busy_low_at_finish", {31'b0, cfg_busy}, 32'd0);
      end
      prev_fin = cfg_done || cfg_error;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #2 cfg_start = 1'b1;
    @(posedge clk); #2 cfg_start = 1'b0;
  endtask

  task automatic wait_fin();
    int k;
    k = 0;
    while (!(cfg_done || cfg_error) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("finish_within_budget", {31'b0, (k < 20000)}, 32'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic end_checks();
    chk("cfg_done", {31'b0, cfg_done}, {31'b0, exp_done});
    chk("cfg_error", {31'b0, cfg_error}, {31'b0, exp_err});
    chk("err_index", 32'(err_index), 32'(exp_eidx));
    chk("err_data", {24'b0, err_data}, {24'b0, exp_edata});
    chk("cfg_busy_idle", {31'b0, cfg_busy}, 32'd0);
    chk("all_txns_issued", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_master();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = $urandom_range(0, MAXR + 1);
      for (int a = 0; a <= MAXR; a++) bad[i][a] = tbl[i][7:0] ^ 8'($urandom_range(1, 255));
    end
  endtask

  task automatic clear_master();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = 0;
      for (int a = 0; a <= MAXR; a++) bad[i][a] = ~tbl[i][7:0];
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    for (int i = 0; i < DEPTH; i++) tbl[i] = 23'h0;
    tbl[0] = {2'b01, 13'h0000, 8'h3C};
    tbl[1] = {2'b10, 13'h0014, 8'hA5};
    tbl[2] = {2'b11, 13'h0000, 8'h02};
    tbl[3] = {2'b01, 13'h0123, 8'h5A};
    tbl[4] = {2'b11, 13'h0000, 8'h00};
    tbl[5] = {2'b10, 13'h1FFF, 8'h0F};
    clear_master();

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outputs", {10'b0, spi_write_en, spi_read_en, spi_data_addr, spi_data_write}, 32'd0);
    chk("rst_status", {15'b0, cfg_busy, cfg_done, cfg_error, err_index, err_data}, 32'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    chk("no_auto_start", {31'b0, cfg_busy}, 32'd0);

    // Run 1: all writes and verifies succeed
    stall_at = -1;
    build_model();
    chk_lat = 1'b1;
    pulse_start();
    wait_fin();
    end_checks();

    // Run 2: verify of entry 1 always reads 0x00 -> retries exhausted
    clear_master();
    mm[1] = MAXR + 1;
    for (int a = 0; a <= MAXR; a++) bad[1][a] = 8'h00;
    build_model();
    chk_lat = 1'b1;
    pulse_start();
    wait_fin();
    end_checks();

    // Runs 3..6: random mismatch counts and wrong bytes; a start while busy
    for (int r = 0; r < 4; r++) begin
      rand_master();
      build_model();
      pulse_start();
      repeat (40) @(posedge clk);
      #2;
      chk("busy_mid_run", {31'b0, cfg_busy}, 32'd1);
      cfg_start = 1'b1;
      @(posedge clk); #2 cfg_start = 1'b0;
      wait_fin();
      end_checks();
    end

    // Runs 7..8: master never answers one transaction -> watchdog
    for (int r = 0; r < 2; r++) begin
      clear_master();
      stall_at = $urandom_range(0, 5);
      build_model();
      pulse_start();
      wait_fin();
      end_checks();
      chk("timeout_latency", err_cyc - last_en, TMO + 1);
    end
    stall_at = -1;

    // Run 9: reset while waiting for a read, then rerun from index 0
    clear_master();
    build_model();
    pulse_start();
    k = 0;
    while (txn_n < 3 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_read_wait", {31'b0, (k < 2000)}, 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {10'b0, spi_write_en, spi_read_en, spi_data_addr, spi_data_write}, 32'd0);
    chk("midrst_status", {15'b0, cfg_busy, cfg_done, cfg_error, err_index, err_data}, 32'd0);
    exp_q.delete(); gap_q.delete(); rd_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    chk("post_rst_idle", {29'b0, cfg_busy, cfg_done, cfg_error}, 32'd0);
    build_model();
    chk_lat = 1'b1;
    pulse_start();
    wait_fin();
    end_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
